// File: rtl/reg_disp_pkg.sv
// reg_disp_pkg
// Shared constants for the register display scanner: widths, the sixteen
// active-low hex segment patterns (bit order g..a), and the blank pattern.
// No ports; imported with "import reg_disp_pkg::*;".
package reg_disp_pkg;

  localparam int DIGIT_W = 3;
  localparam int SEL_W   = 5;

  // Full 8-bit pattern (dp + g..a) that turns every segment off
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low g..a patterns for hex digits 0..F
  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode
// Combinational hex-to-7-segment decoder, active-low outputs.
// Ports:
//   nibble  in  4 : hex value to show
//   seg     out 7 : segment drive, bit 6 = g ... bit 0 = a, low = lit
module seg7_decode
  import reg_disp_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Straight lookup of the package patterns
  always_comb begin
    seg = SEG_0;
    case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_0;
    endcase
  end

endmodule

// File: rtl/reg_display_scanner.sv
// reg_display_scanner
// Board-side front end for the single-cycle CPU: steps Reg_Sel through the
// 32 architectural registers (automatically or by manual load), captures the
// returned Reg_Data and shows it as eight hex digits on a time-multiplexed,
// active-low 7-segment display.
// Parameters:
//   SCAN_DIV : clock cycles per digit slot (>= 2)
//   STEP_DIV : clock cycles per automatic register advance (>= 2)
// Ports:
//   clk       in  1  : system clock, rising edge
//   rst       in  1  : asynchronous active-high reset
//   Reg_Data  in  32 : value of the register selected by Reg_Sel
//   hold      in  1  : freeze register stepping (dp lit on digit 0)
//   load      in  1  : single-cycle pulse, Reg_Sel <= sel_in
//   sel_in    in  5  : manual register index
//   Reg_Sel   out 5  : register index to the CPU
//   an        out 8  : digit enables, active low, bit 0 = rightmost digit
//   seg       out 8  : segments, active low, bit 7 = dp, bits 6..0 = g..a
// Build option: define REG_DISP_LZB_EN for leading-zero blanking.
module reg_display_scanner
  import reg_disp_pkg::*;
#(
  parameter int SCAN_DIV = 100000,
  parameter int STEP_DIV = 100000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      Reg_Data,
  input  logic             hold,
  input  logic             load,
  input  logic [SEL_W-1:0] sel_in,
  output logic [SEL_W-1:0] Reg_Sel,
  output logic [7:0]       an,
  output logic [7:0]       seg
);

  localparam int STEP_W = $clog2(STEP_DIV);
  localparam int SCAN_W = $clog2(SCAN_DIV);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_DIV - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

  logic [STEP_W-1:0]  step_cnt_q, step_cnt_d;
  logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
  logic [DIGIT_W-1:0] digit_q, digit_d;
  logic [SEL_W-1:0]   reg_sel_q, reg_sel_d;
  logic [31:0]        data_q, data_d;
  logic [7:0]         an_q, an_d;
  logic [7:0]         seg_q, seg_d;

  logic [3:0] cur_nibble;
  logic [6:0] cur_seg;
  logic       blank;

  // Load outranks hold, which outranks the step tick; both load and hold
  // restart the step period so the next advance is a full STEP_DIV away.
  always_comb begin
    reg_sel_d  = reg_sel_q;
    step_cnt_d = step_cnt_q + 1'b1;
    if (load) begin
      reg_sel_d  = sel_in;
      step_cnt_d = '0;
    end else if (hold) begin
      step_cnt_d = '0;
    end else if (step_cnt_q == STEP_LAST) begin
      reg_sel_d  = reg_sel_q + 1'b1;
      step_cnt_d = '0;
    end
  end

  // Digit slot timing, independent of stepping
  always_comb begin
    scan_cnt_d = scan_cnt_q + 1'b1;
    digit_d    = digit_q;
    if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_d = '0;
      digit_d    = digit_q + 1'b1;
    end
  end

  assign data_d     = Reg_Data;
  assign cur_nibble = data_q[{digit_q, 2'b00} +: 4];

  seg7_decode u_decode (
    .nibble (cur_nibble),
    .seg    (cur_seg)
  );

  // A digit above 0 is a leading zero when it and every nibble above it are 0
`ifdef REG_DISP_LZB_EN
  assign blank = (digit_q != '0) && ((data_q >> {digit_q, 2'b00}) == 32'd0);
`else
  assign blank = 1'b0;
`endif

  // Output drive for the current digit; dp on digit 0 flags hold mode
  always_comb begin
    an_d  = ~(8'b1 << digit_q);
    seg_d = {~(hold && (digit_q == '0)), cur_seg};
    if (blank) begin
      an_d  = 8'hFF;
      seg_d = SEG_BLANK;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_cnt_q <= '0;
      scan_cnt_q <= '0;
      digit_q    <= '0;
      reg_sel_q  <= '0;
      data_q     <= '0;
      an_q       <= 8'hFE;
      seg_q      <= 8'hC0;
    end else begin
      step_cnt_q <= step_cnt_d;
      scan_cnt_q <= scan_cnt_d;
      digit_q    <= digit_d;
      reg_sel_q  <= reg_sel_d;
      data_q     <= data_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
    end
  end

  assign Reg_Sel = reg_sel_q;
  assign an      = an_q;
  assign seg     = seg_q;

endmodule

// File: doc/reg_display_scanner.md
# reg_display_scanner

Board-side front end for the single-cycle CPU top. Drives the top's `Reg_Sel` register-select input and consumes its `Reg_Data` output. Steps automatically, or on manual load, through the 32 architectural registers. Shows the selected 32-bit value as eight hex digits on a time-multiplexed, active-low 7-segment display.

## Interface
Parameters:
- `SCAN_DIV`, default 100000: clock cycles per digit slot; must be ≥ 2.
- `STEP_DIV`, default 100000000: clock cycles per automatic register advance; must be ≥ 2.

Ports:
- `clk`  in  1: system clock; all state on rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `Reg_Data`  in  32: register value returned by the CPU top for the current `Reg_Sel`.
- `hold`  in  1: freeze register stepping.
- `load`  in  1: single-cycle pulse; load `sel_in` into `Reg_Sel`.
- `sel_in`  in  5: manual register index.
- `Reg_Sel`  out  5: register index driven to the CPU top.
- `an`  out  8: digit enables, active low; bit i enables digit i (digit 0 rightmost).
- `seg`  out  8: segments, active low; bit 7 = dp, bits 6..0 = g..a.

## Operation
- **Step counter** `step_cnt` counts 0..STEP_DIV-1 and wraps. The step tick fires in the cycle `step_cnt == STEP_DIV-1`.
  - On a step tick with `hold` low: `Reg_Sel <= Reg_Sel + 1`, mod 32, so 31 wraps to 0.
  - While `hold` is high, `step_cnt` is cleared to 0 and `Reg_Sel` is frozen.
- **Load**: `load` high sets `Reg_Sel <= sel_in` and clears `step_cnt` to 0.
  - Load beats both a step tick and `hold`.
- **Data capture**: `data_q <= Reg_Data` every cycle. `Reg_Data` is a combinational read of `Reg_Sel`, so `data_q` reflects a new `Reg_Sel` one cycle after the change.
- **Scan counter** `scan_cnt` counts 0..SCAN_DIV-1 and wraps. At the wrap, `digit` (3 bits) increments, and 7 wraps to 0.
- **Outputs**: registered.
  - `an <= ~(8'b1 << digit)`.
  - `seg[6:0] <= hex7(data_q[4*digit +: 4])`.
  - `seg[7] <= ~(hold && digit == 0)`: the dp marks hold mode on digit 0.
- **Hex encoding** (g..a, active low): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.

## Timing
- **Reset values**: `Reg_Sel=0`, `step_cnt=0`, `scan_cnt=0`, `digit=0`, `data_q=0`, `an=8'hFE`, `seg=8'hC0`.
- **Reset mid-scan** returns all state to the reset values immediately, without waiting for a clock edge.
- **Latency**:
  - `Reg_Sel` change to `data_q` update: 1 cycle.
  - `digit` change to `an`/`seg` update: 1 cycle.
  - `Reg_Sel` change to the new value on the display: ≤ 2 cycles plus the remaining scan slot.
- **Step period**: exactly STEP_DIV cycles between advances when no load or hold intervenes.
- **First advance after reset**: `Reg_Sel` becomes 1 at cycle STEP_DIV.
- **After `load` or release of `hold`**: the next advance occurs STEP_DIV cycles later.
- **Digit slot**: exactly SCAN_DIV cycles. The full refresh period is 8·SCAN_DIV cycles.
- **Enables**: exactly one `an` bit is low at any time, except for blanked digits (see Configuration).

## Configuration
- **`REG_DISP_LZB_EN` defined**: leading-zero blanking.
  - A digit i > 0 is blanked when all nibbles i..7 of `data_q` are zero.
  - A blanked digit drives `an=8'hFF` and `seg=8'hFF` for its slot.
  - Slot timing is unchanged.
  - Digit 0 is never blanked.
- **Undefined**: all eight digits are always shown; leading zeros display as 40.

## Structure
- **Shared package** `reg_disp_pkg`:
  - The 16 segment-pattern constants.
  - `SEG_BLANK = 8'hFF`.
  - `DIGIT_W = 3`, `SEL_W = 5`.
- **Sub-module** `seg7_decode`: combinational 4-bit nibble in, 7-bit g..a out, active low.
  - Instantiated once, fed by the digit mux.
- All counters and output registers are in `reg_display_scanner`.

## Test plan
- **Reset**: assert `rst` mid-run → `Reg_Sel=0`, `an=8'hFE`, `seg=8'hC0` asynchronously. The first step occurs STEP_DIV cycles after release.
- **Auto step** (STEP_DIV=4, `hold`=0): `Reg_Sel` goes 0,1,2… every 4 cycles. Preload to 31 via `load` → the next value is 0.
- **Scan** (SCAN_DIV=2, `Reg_Data=32'h1234ABCD`):
  - `an` walks FE,FD,FB,…,7F,FE every 2 cycles.
  - Digit 0 shows `seg=8'hA1`; digit 7 shows `seg=8'hF9`.
- **Load vs. step**: `load` with `sel_in=29` in the step-tick cycle → `Reg_Sel=29`; it becomes 30 exactly STEP_DIV cycles later.
- **Hold**: hold high for 3·STEP_DIV cycles → `Reg_Sel` is constant, and `seg[7]=0` only while digit 0 is enabled.
- **Blanking** (`Reg_Data=32'h000000A5`, SCAN_DIV=2):
  - With `REG_DISP_LZB_EN`: digits 0 and 1 show 92 and 88, digits 2–7 drive `an=8'hFF`.
  - Without the macro: digits 2–7 show `seg=8'hC0`.
